// File: rtl/tetris_game_sequencer.sv
// rtl/tetris_game_sequencer.sv - game controller sequencing the move_piece datapath
// Holds the locked board and active piece, issues move requests, clears rows, spawns pieces.
module tetris_game_sequencer #(
  parameter logic [15:0] GRAV_DIV     = 16'd50000,
  parameter logic [4:0]  SPAWN_LOC    = 5'd29,
  parameter logic [3:0]  LFSR_SEED    = 4'b1001,
  parameter logic [7:0]  DONE_TIMEOUT = 8'd16
) (
  input  logic        clka,
  input  logic        rst_n,
  input  logic        start_game,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_rotate,
  output logic        mp_start,
  output logic        mp_left,
  output logic        mp_right,
  output logic        mp_rotate,
  output logic [31:0] mp_board,
  output logic [1:0]  mp_piece_type,
  output logic [4:0]  mp_location,
  output logic [1:0]  mp_rotation,
  input  logic        mp_done,
  input  logic        mp_touched,
  input  logic [4:0]  mp_new_location,
  input  logic [1:0]  mp_new_rotation,
  input  logic [31:0] mp_new_board,
  output logic [31:0] board_out,
  output logic [7:0]  score,
  output logic        game_over
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPAWN,
    S_PLAY,
    S_WAIT,
    S_CLEAR,
    S_OVER
  } state_t;

  state_t      state;
  state_t      state_nx;

  logic [31:0] board;
  logic [3:0]  lfsr;
  logic [15:0] grav_cnt;
  logic        grav_pend;
  logic        pend_left;
  logic        pend_right;
  logic        pend_rot;
  logic        btn_left_q;
  logic        btn_right_q;
  logic        btn_rotate_q;
  logic [7:0]  wait_cnt;
  logic [2:0]  row_idx;

  logic        rise_left;
  logic        rise_right;
  logic        rise_rot;
  logic        req_any;
  logic        issue;
  logic        sel_rot;
  logic        sel_left;
  logic        sel_right;
  logic        sel_grav;
  logic        grav_tick;
  logic        wait_expired;
  logic        row_full;
  logic [31:0] board_shifted;

  assign rise_left  = btn_left & ~btn_left_q;
  assign rise_right = btn_right & ~btn_right_q;
  assign rise_rot   = btn_rotate & ~btn_rotate_q;

  assign req_any   = pend_rot | pend_left | pend_right | grav_pend;
  assign issue     = (state == S_PLAY) && req_any;
  assign sel_rot   = pend_rot;
  assign sel_left  = ~pend_rot & pend_left;
  assign sel_right = ~pend_rot & ~pend_left & pend_right;
  assign sel_grav  = ~pend_rot & ~pend_left & ~pend_right & grav_pend;

  assign grav_tick    = (state == S_PLAY) && (grav_cnt == GRAV_DIV - 16'd1);
  assign wait_expired = (wait_cnt == DONE_TIMEOUT - 8'd1);
  assign row_full     = (board[{row_idx, 2'b00} +: 4] == 4'hF);

  assign mp_board  = board;
  assign board_out = board;
  assign game_over = (state == S_OVER);

  // Drop row row_idx: everything above it moves down one row, top row refills with zeros.
  always_comb begin
    board_shifted = board;
    for (int r = 0; r < 8; r++) begin
      if (3'(r) >= row_idx) begin
        if (r == 7) begin
          board_shifted[4*r +: 4] = 4'h0;
        end else begin
          board_shifted[4*r +: 4] = board[4*(r+1) +: 4];
        end
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start_game) state_nx = S_SPAWN;
      S_SPAWN: state_nx = (board[31:28] != 4'h0) ? S_OVER : S_PLAY;
      S_PLAY:  if (req_any) state_nx = S_WAIT;
      S_WAIT: begin
        if (mp_done) begin
          state_nx = mp_touched ? S_CLEAR : S_PLAY;
        end else if (wait_expired) begin
          state_nx = S_PLAY;
        end
      end
      S_CLEAR: if (!row_full && row_idx == 3'd7) state_nx = S_SPAWN;
      S_OVER:  if (start_game) state_nx = S_SPAWN;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      board         <= 32'h0;
      score         <= 8'h0;
      lfsr          <= LFSR_SEED;
      grav_cnt      <= 16'h0;
      grav_pend     <= 1'b0;
      pend_left     <= 1'b0;
      pend_right    <= 1'b0;
      pend_rot      <= 1'b0;
      btn_left_q    <= 1'b0;
      btn_right_q   <= 1'b0;
      btn_rotate_q  <= 1'b0;
      mp_start      <= 1'b0;
      mp_left       <= 1'b0;
      mp_right      <= 1'b0;
      mp_rotate     <= 1'b0;
      mp_piece_type <= 2'b00;
      mp_location   <= 5'd0;
      mp_rotation   <= 2'd0;
      wait_cnt      <= 8'h0;
      row_idx       <= 3'd0;
    end else begin
      lfsr         <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
      btn_left_q   <= btn_left;
      btn_right_q  <= btn_right;
      btn_rotate_q <= btn_rotate;

      // A new edge wins over the clear so a press landing on its own issue cycle survives.
      if (state == S_SPAWN)       pend_rot <= 1'b0;
      else if (rise_rot)          pend_rot <= 1'b1;
      else if (issue && sel_rot)  pend_rot <= 1'b0;

      if (state == S_SPAWN)       pend_left <= 1'b0;
      else if (rise_left)         pend_left <= 1'b1;
      else if (issue && sel_left) pend_left <= 1'b0;

      if (state == S_SPAWN)        pend_right <= 1'b0;
      else if (rise_right)         pend_right <= 1'b1;
      else if (issue && sel_right) pend_right <= 1'b0;

      if (grav_tick) begin
        grav_cnt  <= 16'h0;
        grav_pend <= 1'b1;
      end else begin
        if (state == S_PLAY) grav_cnt <= grav_cnt + 16'd1;
        if (issue && sel_grav) grav_pend <= 1'b0;
      end

      mp_start <= issue;
      if (issue) begin
        mp_rotate <= sel_rot;
        mp_left   <= sel_left;
        mp_right  <= sel_right;
        wait_cnt  <= 8'h0;
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt + 8'd1;
        if (mp_done || wait_expired) begin
          mp_rotate <= 1'b0;
          mp_left   <= 1'b0;
          mp_right  <= 1'b0;
        end
      end

      case (state)
        S_IDLE, S_OVER: begin
          if (start_game) begin
            board <= 32'h0;
            score <= 8'h0;
          end
        end
        S_SPAWN: begin
          mp_location   <= SPAWN_LOC;
          mp_rotation   <= 2'd0;
          mp_piece_type <= lfsr[1:0];
        end
        S_WAIT: begin
          if (mp_done) begin
            mp_location <= mp_new_location;
            mp_rotation <= mp_new_rotation;
            if (mp_touched) begin
              board   <= mp_new_board;
              row_idx <= 3'd0;
            end
          end
        end
        S_CLEAR: begin
          if (row_full) begin
            board <= board_shifted;
            if (score != 8'hFF) score <= score + 8'd1;
          end else if (row_idx != 3'd7) begin
            row_idx <= row_idx + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tetris_game_sequencer.sv
// tb/tb_tetris_game_sequencer.sv - directed bench for tetris_game_sequencer
// Drives a scripted move_piece responder and checks board, score, piece and request ordering.
module tb_tetris_game_sequencer;

  logic        clka = 1'b0;
  logic        rst_n;
  logic        start_game;
  logic        btn_left;
  logic        btn_right;
  logic        btn_rotate;
  logic        mp_start;
  logic        mp_left;
  logic        mp_right;
  logic        mp_rotate;
  logic [31:0] mp_board;
  logic [1:0]  mp_piece_type;
  logic [4:0]  mp_location;
  logic [1:0]  mp_rotation;
  logic        mp_done;
  logic        mp_touched;
  logic [4:0]  mp_new_location;
  logic [1:0]  mp_new_rotation;
  logic [31:0] mp_new_board;
  logic [31:0] board_out;
  logic [7:0]  score;
  logic        game_over;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clka = ~clka;

  tetris_game_sequencer #(
    .GRAV_DIV    (16'd4),
    .SPAWN_LOC   (5'd29),
    .LFSR_SEED   (4'b1001),
    .DONE_TIMEOUT(8'd16)
  ) dut (
    .clka           (clka),
    .rst_n          (rst_n),
    .start_game     (start_game),
    .btn_left       (btn_left),
    .btn_right      (btn_right),
    .btn_rotate     (btn_rotate),
    .mp_start       (mp_start),
    .mp_left        (mp_left),
    .mp_right       (mp_right),
    .mp_rotate      (mp_rotate),
    .mp_board       (mp_board),
    .mp_piece_type  (mp_piece_type),
    .mp_location    (mp_location),
    .mp_rotation    (mp_rotation),
    .mp_done        (mp_done),
    .mp_touched     (mp_touched),
    .mp_new_location(mp_new_location),
    .mp_new_rotation(mp_new_rotation),
    .mp_new_board   (mp_new_board),
    .board_out      (board_out),
    .score          (score),
    .game_over      (game_over)
  );

  typedef struct {
    logic        touched;
    logic [4:0]  loc;
    logic [1:0]  rot;
    logic [31:0] nb;
    logic        hold_start;
    logic [4:0]  e_loc;
    logic [1:0]  e_rot;
    logic [31:0] e_board;
    logic [7:0]  e_score;
    logic        e_over;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic respond(input logic t, input logic [4:0] loc, input logic [1:0] rot,
                         input logic [31:0] nb);
    mp_done         = 1'b1;
    mp_touched      = t;
    mp_new_location = loc;
    mp_new_rotation = rot;
    mp_new_board    = nb;
    tick();
    mp_done    = 1'b0;
    mp_touched = 1'b0;
  endtask

  // Waits for the next request pulse or game over; returns the cycles spent waiting.
  task automatic wait_req(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      n++;
      if (mp_start || game_over) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL wait_req: no mp_start/game_over within 200 cycles");
  endtask

  initial begin
    int n;
    int cnt;
    logic saw_start;

    vecs[0] = '{1'b0, 5'd25, 2'd1, 32'h0,         1'b0, 5'd25, 2'd1, 32'h0,         8'd0, 1'b0};
    vecs[1] = '{1'b0, 5'd21, 2'd2, 32'h0,         1'b0, 5'd21, 2'd2, 32'h0,         8'd0, 1'b0};
    vecs[2] = '{1'b1, 5'd1,  2'd0, 32'h0000_000F, 1'b0, 5'd29, 2'd0, 32'h0,         8'd1, 1'b0};
    vecs[3] = '{1'b1, 5'd2,  2'd1, 32'h0000_0FFF, 1'b0, 5'd29, 2'd0, 32'h0,         8'd4, 1'b0};
    vecs[4] = '{1'b1, 5'd0,  2'd0, 32'h0000_F1F2, 1'b0, 5'd29, 2'd0, 32'h0000_0012, 8'd6, 1'b0};
    vecs[5] = '{1'b1, 5'd0,  2'd0, 32'h0000_0312, 1'b1, 5'd29, 2'd0, 32'h0000_0312, 8'd6, 1'b0};
    vecs[6] = '{1'b1, 5'd0,  2'd0, 32'hF000_0312, 1'b0, 5'd29, 2'd0, 32'h0000_0312, 8'd7, 1'b0};
    vecs[7] = '{1'b0, 5'd13, 2'd2, 32'h0,         1'b0, 5'd13, 2'd2, 32'h0000_0312, 8'd7, 1'b0};
    vecs[8] = '{1'b1, 5'd13, 2'd2, 32'h1000_0312, 1'b0, 5'd29, 2'd0, 32'h1000_0312, 8'd7, 1'b1};

    rst_n = 1'b0;
    start_game = 1'b0;
    btn_left = 1'b0;
    btn_right = 1'b0;
    btn_rotate = 1'b0;
    mp_done = 1'b0;
    mp_touched = 1'b0;
    mp_new_location = 5'd0;
    mp_new_rotation = 2'd0;
    mp_new_board = 32'h0;
    tick();
    tick();
    check("rst_mp_start", 32'(mp_start), 32'd0);
    check("rst_mp_left", 32'(mp_left), 32'd0);
    check("rst_mp_right", 32'(mp_right), 32'd0);
    check("rst_mp_rotate", 32'(mp_rotate), 32'd0);
    check("rst_location", 32'(mp_location), 32'd0);
    check("rst_rotation", 32'(mp_rotation), 32'd0);
    check("rst_piece_type", 32'(mp_piece_type), 32'd0);
    check("rst_board_out", board_out, 32'h0);
    check("rst_mp_board", mp_board, 32'h0);
    check("rst_score", 32'(score), 32'd0);
    check("rst_game_over", 32'(game_over), 32'd0);
    rst_n = 1'b1;
    tick();

    // Gravity only: requests carry no direction and repeat every GRAV_DIV + 1-cycle handshake.
    start_game = 1'b1;
    tick();
    start_game = 1'b0;
    wait_req(n);
    check("grav1_dirs", {29'd0, mp_left, mp_right, mp_rotate}, 32'd0);
    check("grav1_loc", 32'(mp_location), 32'd29);
    respond(1'b0, 5'd29, 2'd0, 32'h0);
    wait_req(n);
    check("grav_period", 32'(n + 1), 32'd5);
    check("grav2_dirs", {29'd0, mp_left, mp_right, mp_rotate}, 32'd0);
    check("grav2_loc", 32'(mp_location), 32'd29);

    // Left and rotate rising together: rotate first, then left, then gravity.
    btn_left = 1'b1;
    btn_rotate = 1'b1;
    respond(1'b0, 5'd29, 2'd0, 32'h0);
    btn_left = 1'b0;
    btn_rotate = 1'b0;
    wait_req(n);
    check("prio1_lrr", {29'd0, mp_left, mp_right, mp_rotate}, 32'b001);
    respond(1'b0, 5'd29, 2'd1, 32'h0);
    wait_req(n);
    check("prio2_lrr", {29'd0, mp_left, mp_right, mp_rotate}, 32'b100);
    check("prio2_rot", 32'(mp_rotation), 32'd1);
    respond(1'b0, 5'd28, 2'd1, 32'h0);
    wait_req(n);
    check("prio3_lrr", {29'd0, mp_left, mp_right, mp_rotate}, 32'b000);
    check("prio3_loc", 32'(mp_location), 32'd28);

    for (int v = 0; v < 9; v++) begin
      start_game = vecs[v].hold_start;
      respond(vecs[v].touched, vecs[v].loc, vecs[v].rot, vecs[v].nb);
      wait_req(n);
      start_game = 1'b0;
      check($sformatf("vec%0d_loc", v), 32'(mp_location), 32'(vecs[v].e_loc));
      check($sformatf("vec%0d_rot", v), 32'(mp_rotation), 32'(vecs[v].e_rot));
      check($sformatf("vec%0d_board_out", v), board_out, vecs[v].e_board);
      check($sformatf("vec%0d_mp_board", v), mp_board, vecs[v].e_board);
      check($sformatf("vec%0d_score", v), 32'(score), 32'(vecs[v].e_score));
      check($sformatf("vec%0d_game_over", v), 32'(game_over), 32'(vecs[v].e_over));
    end

    // Game over holds the board until start_game restarts with a clean board.
    tick();
    tick();
    check("over_hold_board", board_out, 32'h1000_0312);
    check("over_hold_flag", 32'(game_over), 32'd1);
    start_game = 1'b1;
    tick();
    start_game = 1'b0;
    wait_req(n);
    check("restart_board", board_out, 32'h0);
    check("restart_score", 32'(score), 32'd0);
    check("restart_over", 32'(game_over), 32'd0);
    check("restart_loc", 32'(mp_location), 32'd29);
    check("restart_mp_start", 32'(mp_start), 32'd1);

    // No mp_done for a left request: abandoned after DONE_TIMEOUT cycles, piece unchanged.
    btn_left = 1'b1;
    respond(1'b0, 5'd17, 2'd3, 32'h0);
    btn_left = 1'b0;
    wait_req(n);
    check("to_is_left", {29'd0, mp_left, mp_right, mp_rotate}, 32'b100);
    cnt = mp_left ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (mp_left) cnt++;
      else break;
    end
    check("to_hold_cycles", 32'(cnt), 32'd16);
    check("to_loc", 32'(mp_location), 32'd17);
    check("to_rot", 32'(mp_rotation), 32'd3);
    wait_req(n);
    check("to_next_req", 32'(mp_start), 32'd1);
    check("to_next_loc", 32'(mp_location), 32'd17);
    check("to_next_rot", 32'(mp_rotation), 32'd3);

    // Full boards, 8 rows each: score saturates at 255.
    for (int k = 0; k < 32; k++) begin
      respond(1'b1, 5'd0, 2'd0, 32'hFFFF_FFFF);
      wait_req(n);
      if (k == 30) check("sat_score_248", 32'(score), 32'd248);
    end
    check("sat_score_255", 32'(score), 32'd255);
    check("sat_board", board_out, 32'h0);

    // Asynchronous reset in WAIT, then a late mp_done that must be ignored.
    respond(1'b1, 5'd0, 2'd0, 32'h0000_0100);
    wait_req(n);
    check("pre_rst_board", board_out, 32'h0000_0100);
    check("pre_rst_start", 32'(mp_start), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_mp_start", 32'(mp_start), 32'd0);
    check("arst_dirs", {29'd0, mp_left, mp_right, mp_rotate}, 32'd0);
    check("arst_board", board_out, 32'h0);
    check("arst_score", 32'(score), 32'd0);
    check("arst_loc", 32'(mp_location), 32'd0);
    check("arst_game_over", 32'(game_over), 32'd0);
    tick();
    rst_n = 1'b1;
    respond(1'b1, 5'd9, 2'd2, 32'hFFFF_0000);
    saw_start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (mp_start) saw_start = 1'b1;
    end
    check("late_done_no_start", 32'(saw_start), 32'd0);
    check("late_done_board", board_out, 32'h0);
    check("late_done_loc", 32'(mp_location), 32'd0);
    check("late_done_rot", 32'(mp_rotation), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
